// File: rtl/imem_pkg.sv
// Shared constants and response record for the instruction memory responder.
package imem_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_WORD_DEFAULT = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic            err;
  } imem_rsp_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Two-entry shift FIFO holding fetched responses; the head entry drives the
// response port directly from flops.
module imem_rsp_fifo
  import imem_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  imem_rsp_t push_data,
  input  logic      pop,
  output imem_rsp_t head,
  output logic      head_valid,
  output logic      full
);

  imem_rsp_t head_q, head_d;
  imem_rsp_t tail_q, tail_d;
  logic      head_vld_q, head_vld_d;
  logic      tail_vld_q, tail_vld_d;

  // Next-state: tail valid implies head valid, so three occupancy cases.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    head_vld_d = head_vld_q;
    tail_vld_d = tail_vld_q;
    if (!head_vld_q) begin
      if (push) begin
        head_d     = push_data;
        head_vld_d = 1'b1;
      end
    end else if (!tail_vld_q) begin
      if (pop && push) begin
        head_d = push_data;
      end else if (pop) begin
        head_vld_d = 1'b0;
      end else if (push) begin
        tail_d     = push_data;
        tail_vld_d = 1'b1;
      end
    end else begin
      if (pop) begin
        head_d     = tail_q;
        tail_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      head_vld_q <= 1'b0;
      tail_vld_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      head_vld_q <= head_vld_d;
      tail_vld_q <= tail_vld_d;
    end
  end

  assign head       = head_q;
  assign head_valid = head_vld_q;
  assign full       = tail_vld_q;

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction memory with a fetch request/response handshake and a load port.
// Define IMEM_ERR_CHECK_EN to flag misaligned / out-of-range fetches.
module instr_mem_responder
  import imem_pkg::*;
#(
  parameter int unsigned     DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] NOP_WORD    = NOP_WORD_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_instr,
  output logic            rsp_err,
  input  logic            load_en,
  input  logic [XLEN-1:0] load_addr,
  input  logic [XLEN-1:0] load_data
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  logic            req_acc_c;
  logic            rsp_pop_c;
  logic            fifo_full_c;
  logic            wr_en_c;
  logic [AW-1:0]   rd_idx_c;
  logic [AW-1:0]   wr_idx_c;
  imem_rsp_t       rd_rsp_c;
  imem_rsp_t       head_c;
  logic            unused_c;

  // Readiness depends only on FIFO flops (and reset), never on req_valid.
  assign req_ready = !reset && !fifo_full_c;
  assign req_acc_c = req_valid && req_ready;
  assign rsp_pop_c = rsp_valid && rsp_ready;

  assign rd_idx_c = req_addr[AW+1:2];
  assign wr_idx_c = load_addr[AW+1:2];

`ifdef IMEM_ERR_CHECK_EN
  localparam logic [XLEN-1:0] BYTE_LIMIT = XLEN'(4 * DEPTH_WORDS);

  logic req_bad_c;

  always_comb begin
    req_bad_c      = (req_addr[1:0] != 2'b00) || (req_addr >= BYTE_LIMIT);
    rd_rsp_c.instr = req_bad_c ? NOP_WORD : mem_q[rd_idx_c];
    rd_rsp_c.err   = req_bad_c;
    wr_en_c        = load_en && (load_addr < BYTE_LIMIT);
  end

  assign unused_c = ^{load_addr[1:0]};
`else
  always_comb begin
    rd_rsp_c.instr = mem_q[rd_idx_c];
    rd_rsp_c.err   = 1'b0;
    wr_en_c        = load_en;
  end

  // Address bits outside the word index are intentionally ignored.
  assign unused_c = ^{req_addr[XLEN-1:AW+2], req_addr[1:0],
                      load_addr[XLEN-1:AW+2], load_addr[1:0], NOP_WORD};
`endif

  // Memory is never reset; a same-cycle read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_idx_c] <= load_data;
    end
  end

  // The read word is captured straight into the FIFO at the accept edge.
  imem_rsp_fifo u_rsp_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (req_acc_c),
    .push_data  (rd_rsp_c),
    .pop        (rsp_pop_c),
    .head       (head_c),
    .head_valid (rsp_valid),
    .full       (fifo_full_c)
  );

  assign rsp_instr = head_c.instr;
  assign rsp_err   = head_c.err;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench for instr_mem_responder against a queue-based reference.
module tb_instr_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic        rsp_err;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] model_mem [DEPTH];
  logic [32:0] exp_q [$];
  logic [32:0] got_q [$];

  instr_mem_responder #(.DEPTH_WORDS(DEPTH), .NOP_WORD(NOP)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_err   (rsp_err),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [32:0] model_rsp(input logic [31:0] a);
`ifdef IMEM_ERR_CHECK_EN
    if (a[1:0] != 2'b00 || a >= 32'(4 * DEPTH)) return {NOP, 1'b1};
`endif
    return {model_mem[(a / 4) % DEPTH], 1'b0};
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
`ifdef IMEM_ERR_CHECK_EN
    if (a >= 32'(4 * DEPTH)) return;
`endif
    model_mem[(a / 4) % DEPTH] = d;
  endfunction

  // Advance one cycle: record handshakes seen before the edge, update the model.
  task automatic tick(output logic acc, output logic popped);
    #1;
    acc    = req_valid && req_ready && !reset;
    popped = rsp_valid && rsp_ready && !reset;
    if (reset) begin
      while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
    end else begin
      if (popped) got_q.push_back({rsp_instr, rsp_err});
      if (acc) exp_q.push_back(model_rsp(req_addr));
    end
    if (load_en) model_write(load_addr, load_data);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic a, p;
    reset = 1'b1;
    tick(a, p);
    tick(a, p);
    tests_run++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_instr !== 32'h0 || rsp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: ready=%b valid=%b instr=%h err=%b, want 0 0 00000000 0",
               req_ready, rsp_valid, rsp_instr, rsp_err);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready: got %b want 1", req_ready);
    end
    @(negedge clk);
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_preload();
    logic a, p;
    for (int i = 0; i < int'(DEPTH); i++) begin
      load_en   = 1'b1;
      load_addr = 32'(i * 4);
      load_data = $urandom;
      tick(a, p);
    end
    load_en = 1'b0;
    tests_run++;
    if (rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL preload_no_rsp: rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_basic();
    logic a, p;
    load_en = 1'b1; load_addr = 32'h0; load_data = 32'h0050_0093; tick(a, p);
    load_addr = 32'h4; load_data = 32'h0010_0113; tick(a, p);
    load_en = 1'b0;
    exp_q.delete(); got_q.delete();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h0;
    tests_run++;
    if (rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_no_early_rsp: rsp_valid=%b want 0", rsp_valid);
    end
    tick(a, p);
    tests_run++;
    if (a !== 1'b1 || rsp_valid !== 1'b1 || rsp_instr !== 32'h0050_0093 || rsp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_first: acc=%b valid=%b instr=%h err=%b, want 1 1 00500093 0",
               a, rsp_valid, rsp_instr, rsp_err);
    end
    req_addr = 32'h4;
    tick(a, p);
    tests_run++;
    if (a !== 1'b1 || rsp_valid !== 1'b1 || rsp_instr !== 32'h0010_0113 || rsp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_second: acc=%b valid=%b instr=%h err=%b, want 1 1 00100113 0",
               a, rsp_valid, rsp_instr, rsp_err);
    end
    req_valid = 1'b0;
    tick(a, p);
    tests_run++;
    if (rsp_valid !== 1'b0 || got_q.size() != 2) begin
      tests_failed++;
      $display("FAIL basic_drain: valid=%b responses=%0d, want 0 and 2", rsp_valid, got_q.size());
    end
  endtask

  task automatic test_full();
    logic a, p;
    int   blocked;
    exp_q.delete(); got_q.delete();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0; tick(a, p);
    req_addr = 32'h4; tick(a, p);
    req_addr = 32'h8;
    tests_run++;
    if (req_ready !== 1'b0 || exp_q.size() != 2) begin
      tests_failed++;
      $display("FAIL full_ready_drop: ready=%b accepted=%0d, want 0 and 2", req_ready, exp_q.size());
    end
    blocked = 0;
    for (int i = 0; i < 3; i++) begin
      tick(a, p);
      if (a === 1'b1) blocked++;
    end
    tests_run++;
    if (blocked != 0 || rsp_valid !== 1'b1 || rsp_instr !== model_mem[0]) begin
      tests_failed++;
      $display("FAIL full_hold: extra_accepts=%0d valid=%b instr=%h, want 0 1 %h",
               blocked, rsp_valid, rsp_instr, model_mem[0]);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && got_q.size() < 3; i++) begin
      tick(a, p);
      if (a === 1'b1) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    tests_run++;
    if (got_q.size() != 3 || exp_q.size() != 3) begin
      tests_failed++;
      $display("FAIL full_count: got %0d responses for %0d requests, want 3", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (got_q[i] !== {model_mem[i], 1'b0}) begin
          tests_failed++;
          $display("FAIL full_order[%0d]: got %h want %h", i, got_q[i], {model_mem[i], 1'b0});
        end
      end
    end
  endtask

  task automatic test_err();
    logic        a, p;
    logic [31:0] addrs [2];
    logic [32:0] want;
    addrs[0] = 32'h2;
    addrs[1] = 32'h1000;
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
`ifdef IMEM_ERR_CHECK_EN
      want = {NOP, 1'b1};
`else
      want = {model_mem[0], 1'b0};
`endif
      req_valid = 1'b1; req_addr = addrs[i];
      tick(a, p);
      req_valid = 1'b0;
      tests_run++;
      if (a !== 1'b1 || rsp_valid !== 1'b1 || {rsp_instr, rsp_err} !== want) begin
        tests_failed++;
        $display("FAIL err_addr_%h: acc=%b valid=%b rsp=%h, want 1 1 %h",
                 addrs[i], a, rsp_valid, {rsp_instr, rsp_err}, want);
      end
      tick(a, p);
    end
  endtask

  task automatic test_same_cycle_load();
    logic        a, p;
    logic [31:0] old;
    model_write(32'h8, 32'h1234_5678);
    load_en = 1'b1; load_addr = 32'h8; load_data = 32'h1234_5678;
    tick(a, p);
    old = 32'h1234_5678;
    rsp_ready = 1'b1;
    load_data = 32'hDEAD_BEEF;
    req_valid = 1'b1; req_addr = 32'h8;
    tick(a, p);
    load_en = 1'b0;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_instr !== old) begin
      tests_failed++;
      $display("FAIL same_cycle_old: valid=%b instr=%h want 1 %h", rsp_valid, rsp_instr, old);
    end
    tick(a, p);
    req_valid = 1'b0;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_instr !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL same_cycle_new: valid=%b instr=%h want 1 deadbeef", rsp_valid, rsp_instr);
    end
    tick(a, p);
  endtask

  task automatic test_random();
    logic        a, p;
    logic        prev_hold, cur_valid;
    logic [32:0] prev_val, cur_val;
    exp_q.delete(); got_q.delete();
    prev_hold = 1'b0;
    prev_val  = '0;
    for (int n = 0; n < 400; n++) begin
      req_valid = ($urandom % 3) != 0;
      req_addr  = (($urandom % 5) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1) * 4);
      rsp_ready = ($urandom % 3) != 0;
      load_en   = ($urandom % 4) == 0;
      load_addr = (($urandom % 5) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1) * 4);
      load_data = $urandom;
      if (prev_hold) begin
        tests_run++;
        if (rsp_valid !== 1'b1 || {rsp_instr, rsp_err} !== prev_val) begin
          tests_failed++;
          $display("FAIL rand_hold cycle %0d: valid=%b rsp=%h want 1 %h",
                   n, rsp_valid, {rsp_instr, rsp_err}, prev_val);
        end
      end
      cur_valid = rsp_valid;
      cur_val   = {rsp_instr, rsp_err};
      tick(a, p);
      prev_hold = cur_valid && !rsp_ready;
      prev_val  = cur_val;
    end
    req_valid = 1'b0; load_en = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick(a, p);
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL rand_count: got %0d responses want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got_q.size(); i++) begin
        tests_run++;
        if (got_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL rand_rsp[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic a, p;
    exp_q.delete(); got_q.delete();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0; tick(a, p);
    req_addr = 32'h4; tick(a, p);
    req_valid = 1'b0;
    tests_run++;
    if (rsp_valid !== 1'b1 || exp_q.size() != 2) begin
      tests_failed++;
      $display("FAIL rst_mid_pending: valid=%b accepted=%0d want 1 and 2", rsp_valid, exp_q.size());
    end
    reset = 1'b1;
    tick(a, p);
    tests_run++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_instr !== 32'h0 || req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_clear: valid=%b err=%b instr=%h ready=%b want 0 0 00000000 0",
               rsp_valid, rsp_err, rsp_instr, req_ready);
    end
    reset = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h0;
    tick(a, p);
    req_valid = 1'b0;
    tests_run++;
    if (a !== 1'b1 || rsp_valid !== 1'b1 || rsp_instr !== model_mem[0] || rsp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_refetch: acc=%b valid=%b instr=%h err=%b want 1 1 %h 0",
               a, rsp_valid, rsp_instr, rsp_err, model_mem[0]);
    end
    tick(a, p);
    tests_run++;
    if (got_q.size() != 1 || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_dropped: responses=%0d valid=%b want 1 and 0", got_q.size(), rsp_valid);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    @(negedge clk);
    test_reset();
    test_preload();
    test_basic();
    test_full();
    test_err();
    test_same_cycle_load();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instr_mem_responder.md
INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit instruction words (power of two, >=4).
REQ-002 Parameter NOP_WORD, default 32'h00000013, word returned on error responses.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  fetch request present.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_addr  input  32  byte address of requested instruction (the current PC).
REQ-008 rsp_valid  output  1  response word present.
REQ-009 rsp_ready  input  1  consumer accepts response this cycle.
REQ-010 rsp_instr  output  32  fetched instruction word.
REQ-011 rsp_err  output  1  request was misaligned or out of range.
REQ-012 load_en  input  1  write one word into instruction memory this cycle.
REQ-013 load_addr  input  32  byte address of word to load.
REQ-014 load_data  input  32  word to load.

Function
REQ-015 Request accepted on a cycle with req_valid && req_ready; response accepted on a cycle with rsp_valid && rsp_ready.
REQ-016 Memory read is synchronous, one cycle: request accepted in cycle N yields a response eligible for rsp_valid in cycle N+1, no earlier.
REQ-017 Responses leave in request order, held stable (rsp_instr, rsp_err) while rsp_valid && !rsp_ready.
REQ-018 Read data is captured into a 2-entry response FIFO; req_ready = (in-flight reads + FIFO occupancy) < 2, no combinational path from req_valid.
REQ-019 Sustained req_valid with rsp_ready high gives one response per cycle after the first.
REQ-020 Full: with 2 responses held and rsp_ready low, req_ready is 0 and no request or response is lost.
REQ-021 Word index = req_addr[log2(DEPTH_WORDS)+1:2].
REQ-022 Load write takes effect at the clock edge; read of the same word in the same cycle returns the old word.
REQ-023 Load writes proceed independently of the fetch handshake and of FIFO state.

Reset
REQ-024 On reset: req_ready=0 during reset, 1 in the first cycle after; rsp_valid=0, rsp_instr=0, rsp_err=0; FIFO empty; in-flight read dropped.
REQ-025 Reset mid-operation discards all pending responses; memory contents are preserved.

Configuration
REQ-026 Macro IMEM_ERR_CHECK_EN defined: req_addr[1:0]!=0 or req_addr >= 4*DEPTH_WORDS gives rsp_err=1 and rsp_instr=NOP_WORD, same latency/order as normal; out-of-range load writes are ignored.
REQ-027 Macro IMEM_ERR_CHECK_EN undefined: address low bits and upper bits ignored (index wraps modulo DEPTH_WORDS), rsp_err tied 0.

Structure
REQ-028 Package imem_pkg holds XLEN=32, NOP_WORD default constant and the response record typedef {instr, err}.
REQ-029 Sub-module imem_rsp_fifo implements the 2-entry response FIFO; memory array and handshake control stay in the top.

Verification
REQ-030 Load 0x00500093 at 0x0, 0x00100113 at 0x4; request 0x0 then 0x4, rsp_ready=1 -> responses in cycles N+1, N+2: 0x00500093, 0x00100113, rsp_err=0.
REQ-031 rsp_ready=0, request 0x0, 0x4, 0x8 back-to-back -> req_ready drops after second accept; raise rsp_ready -> three correct words in order, none lost.
REQ-032 IMEM_ERR_CHECK_EN defined: request 0x2 -> rsp_err=1, rsp_instr=0x00000013; request 0x1000 (DEPTH_WORDS=1024) -> rsp_err=1, NOP; undefined: 0x1000 returns word at 0x0, rsp_err=0.
REQ-033 Same-cycle load_en to 0x8 with data 0xDEADBEEF and request 0x8 -> old word returned; next request 0x8 -> 0xDEADBEEF.
REQ-034 Assert reset with two responses pending -> next cycle rsp_valid=0, rsp_err=0, rsp_instr=0; after release, request 0x0 returns preloaded word intact.
